// File: rtl/nibble_serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_add_ctrl_if
// Description : Start/busy/done handshake and operand/result bus of the
//               nibble-serial adder sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface nibble_serial_add_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         cin_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] sum_o;
    logic         cout_o;
    logic         overflow_o;

    modport master (
        output start_i, a_i, b_i, cin_i,
        input  busy_o, done_o, sum_o, cout_o, overflow_o
    );

    modport slave (
        input  start_i, a_i, b_i, cin_i,
        output busy_o, done_o, sum_o, cout_o, overflow_o
    );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_add_ctrl
// Description : Multi-nibble adder built from one shared 4-bit ripple slice,
//               one nibble per clock, LSB nibble first, carry chained.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    nibble_serial_add_ctrl_if.slave bus
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = $clog2(NIBBLES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [IDXW-1:0]   idx_q;
    logic              carry_q;
    logic [W-1:0]      opa_q;
    logic [W-1:0]      opb_q;
    logic [W-1:0]      partial_q;
    logic [W-1:0]      sum_q;
    logic              cout_q;
    logic              ovf_q;

    logic [3:0]        w_na;
    logic [3:0]        w_nb;
    logic [3:0]        w_s;
    logic [4:0]        w_c;
    logic              w_accept;

    assign w_na = opa_q[{idx_q, 2'b00} +: 4];
    assign w_nb = opb_q[{idx_q, 2'b00} +: 4];
    assign w_c[0] = carry_q;

    // Explicit full-adder chain so the carry into bit 3 is available for overflow.
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign w_s[i]   = w_na[i] ^ w_nb[i] ^ w_c[i];
        assign w_c[i+1] = (w_na[i] & w_nb[i]) | (w_c[i] & (w_na[i] ^ w_nb[i]));
    end

    assign w_accept = bus.start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            opa_q     <= '0;
            opb_q     <= '0;
            partial_q <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (w_accept) begin
            opa_q     <= bus.a_i;
            opb_q     <= bus.b_i;
            carry_q   <= bus.cin_i;
            idx_q     <= '0;
            partial_q <= '0;
            state_q   <= S_ADD;
        end else begin
            case (state_q)
                S_ADD: begin
                    partial_q[{idx_q, 2'b00} +: 4] <= w_s;
                    carry_q <= w_c[4];
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        sum_q   <= {w_s, partial_q[W-5:0]};
                        cout_q  <= w_c[4];
                        ovf_q   <= w_c[3] ^ w_c[4];
                        state_q <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                S_IDLE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy_o     = (state_q == S_ADD);
    assign bus.done_o     = (state_q == S_DONE);
    assign bus.sum_o      = sum_q;
    assign bus.cout_o     = cout_q;
    assign bus.overflow_o = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_add_ctrl
// Description : Directed bench for nibble_serial_add_ctrl with a cycle-level
//               arithmetic reference model and literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_add_ctrl;
    localparam int NIB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    nibble_serial_add_ctrl_if #(.NIBBLES(NIB)) ifc ();

    nibble_serial_add_ctrl #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: an accepted add completes NIB clocks later, then reports a+b+cin.
    int          m_rem  = 0;
    logic        m_done = 1'b0;
    logic [15:0] m_sum  = '0;
    logic        m_cout = 1'b0;
    logic        m_ovf  = 1'b0;
    logic [16:0] m_pend = '0;
    logic        m_povf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else begin
            m_done <= (m_rem == 1);
            if (m_rem == 1) begin
                m_sum  <= m_pend[15:0];
                m_cout <= m_pend[16];
                m_ovf  <= m_povf;
            end
            if (m_rem != 0) begin
                m_rem <= m_rem - 1;
            end else if (ifc.start_i) begin
                m_rem  <= NIB;
                m_pend <= {1'b0, ifc.a_i} + {1'b0, ifc.b_i} + {16'd0, ifc.cin_i};
                m_povf <= (ifc.a_i[15] == ifc.b_i[15]) &&
                          (((ifc.a_i + ifc.b_i + {15'd0, ifc.cin_i}) >> 15) != {15'd0, ifc.a_i[15]});
            end
        end
    end

    always @(negedge clk) begin
        chk("m_busy", {31'd0, ifc.busy_o}, {31'd0, (m_rem != 0)});
        chk("m_done", {31'd0, ifc.done_o}, {31'd0, m_done});
        chk("m_sum",  {16'd0, ifc.sum_o},  {16'd0, m_sum});
        chk("m_cout", {31'd0, ifc.cout_o}, {31'd0, m_cout});
        chk("m_ovf",  {31'd0, ifc.overflow_o}, {31'd0, m_ovf});
    end

    task automatic wait_done(output int n);
        n = 0;
        while (!ifc.done_o && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic [15:0] es, input logic ec, input logic eo);
        int nbusy;
        int t;
        ifc.a_i = a; ifc.b_i = b; ifc.cin_i = c; ifc.start_i = 1'b1;
        @(negedge clk);
        ifc.start_i = 1'b0;
        nbusy = 0;
        t = 0;
        while (!ifc.done_o && t < 20) begin
            if (ifc.busy_o) nbusy++;
            @(negedge clk);
            t++;
        end
        chk({nm, "_done"}, {31'd0, ifc.done_o}, 32'd1);
        chk({nm, "_busycycles"}, nbusy, NIB);
        chk({nm, "_sum"}, {16'd0, ifc.sum_o}, {16'd0, es});
        chk({nm, "_cout"}, {31'd0, ifc.cout_o}, {31'd0, ec});
        chk({nm, "_ovf"}, {31'd0, ifc.overflow_o}, {31'd0, eo});
    endtask

    initial begin
        int n;
        bit saw_done;
        ifc.start_i = 1'b0; ifc.a_i = '0; ifc.b_i = '0; ifc.cin_i = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, ifc.busy_o}, 32'd0);
        chk("rst_sum", {16'd0, ifc.sum_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("t1", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        @(negedge clk);
        run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        run_op("t3a", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        // Issued straight from the DONE cycle of t3a.
        run_op("t3b", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
        @(negedge clk);

        // Start held high: the second operand set must wait for the DONE cycle.
        ifc.a_i = 16'h0001; ifc.b_i = 16'h0002; ifc.cin_i = 1'b0; ifc.start_i = 1'b1;
        @(negedge clk);
        ifc.a_i = 16'h1000; ifc.b_i = 16'h0FFF;
        wait_done(n);
        chk("t4_first_sum", {16'd0, ifc.sum_o}, 32'h0003);
        @(negedge clk);
        ifc.start_i = 1'b0;
        n = 1;
        while (!ifc.done_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_period", n, 5);
        chk("t4_second_sum", {16'd0, ifc.sum_o}, 32'h1FFF);
        @(negedge clk);

        // Reset during the second ADD cycle abandons the operation.
        ifc.a_i = 16'h1111; ifc.b_i = 16'h2222; ifc.start_i = 1'b1;
        @(negedge clk);
        ifc.start_i = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy", {31'd0, ifc.busy_o}, 32'd0);
        chk("t5_sum", {16'd0, ifc.sum_o}, 32'd0);
        chk("t5_cout", {31'd0, ifc.cout_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ifc.done_o) saw_done = 1'b1;
        end
        chk("t5_no_done", {31'd0, saw_done}, 32'd0);
        run_op("t5_fresh", 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0);
        @(negedge clk);

        // Operand changes during ADD must not disturb the latched copies.
        ifc.a_i = 16'h0F0F; ifc.b_i = 16'h0101; ifc.cin_i = 1'b0; ifc.start_i = 1'b1;
        @(negedge clk);
        ifc.start_i = 1'b0;
        ifc.a_i = 16'hFFFF; ifc.b_i = 16'hFFFF; ifc.cin_i = 1'b1;
        @(negedge clk);
        chk("t6_sum_hold", {16'd0, ifc.sum_o}, 32'hBCDE);
        wait_done(n);
        chk("t6_done", {31'd0, ifc.done_o}, 32'd1);
        chk("t6_sum", {16'd0, ifc.sum_o}, 32'h1010);
        ifc.cin_i = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_idle_hold", {16'd0, ifc.sum_o}, 32'h1010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
